// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, taken-branch flush and
// data-memory wait handling with a timeout trap, plus a saturating stall counter.
module hazard_ctrl #(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int MAX_WAIT      = 15,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RF_ADDR_WIDTH-1:0] idRs1,
  input  logic [RF_ADDR_WIDTH-1:0] idRs2,
  input  logic                     idUsesRs1,
  input  logic                     idUsesRs2,
  input  logic                     idexMemRead,
  input  logic [RF_ADDR_WIDTH-1:0] idexRd,
  input  logic                     exBranchTaken,
  input  logic                     exmemMemRead,
  input  logic                     dmemReady,
  output logic                     pcWrite,
  output logic                     ifidWrite,
  output logic                     idexWrite,
  output logic                     exmemWrite,
  output logic                     ifidFlush,
  output logic                     idexBubble,
  output logic                     memwbBubble,
  output logic                     memTimeout,
  output logic [CNT_WIDTH-1:0]     stallCount,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  // wait_cnt_q holds the number of stalled cycles already completed; the
  // stalled cycle that would make it MAX_WAIT traps into ST_ERR instead.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t               state_q, state_d;
  logic [7:0]           wait_cnt_q, wait_cnt_d;
  logic                 mem_timeout_q, mem_timeout_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                 br_pend_q, br_pend_d;
  logic                 lu_mask_q, lu_mask_d;

  logic mem_stall;
  logic load_use;
  logic branch_eff;
  logic lu_bubble;

  assign mem_stall  = (state_q != ST_ERR) && exmemMemRead && !dmemReady;
  assign load_use   = idexMemRead && (idexRd != '0) &&
                      ((idUsesRs1 && (idRs1 == idexRd)) ||
                       (idUsesRs2 && (idRs2 == idexRd)));
  // A branch seen while EX was frozen is remembered until the stall releases.
  assign branch_eff = exBranchTaken || br_pend_q;
  assign lu_bubble  = (state_q != ST_ERR) && !mem_stall && !branch_eff &&
                      load_use && !lu_mask_q;

  always_comb begin
    pcWrite     = 1'b1;
    ifidWrite   = 1'b1;
    idexWrite   = 1'b1;
    exmemWrite  = 1'b1;
    ifidFlush   = 1'b0;
    idexBubble  = 1'b0;
    memwbBubble = 1'b0;
    if (state_q == ST_ERR || mem_stall) begin
      pcWrite     = 1'b0;
      ifidWrite   = 1'b0;
      idexWrite   = 1'b0;
      exmemWrite  = 1'b0;
      memwbBubble = 1'b1;
    end else if (branch_eff) begin
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
    end else if (lu_bubble) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    br_pend_d  = 1'b0;
    lu_mask_d  = 1'b0;
    unique case (state_q)
      ST_RUN, ST_WAIT: begin
        if (mem_stall) begin
          br_pend_d = br_pend_q | exBranchTaken;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = ST_ERR;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
          lu_mask_d  = lu_bubble;
        end
      end
      default: state_d = ST_ERR;
    endcase
  end

  always_comb begin
    mem_timeout_d = mem_timeout_q | (state_d == ST_ERR);
    stall_cnt_d   = stall_cnt_q;
    if (!pcWrite && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      br_pend_q     <= 1'b0;
      lu_mask_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      br_pend_q     <= br_pend_d;
      lu_mask_q     <= lu_mask_d;
    end
  end

  assign memTimeout = mem_timeout_q;
  assign stallCount = stall_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a rule-level reference model compared
// every cycle, plus literal expectations at key points of each scenario.
module tb_hazard_ctrl;
  localparam int AW = 5;
  localparam int MW = 4;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] idRs1, idRs2, idexRd;
  logic          idUsesRs1, idUsesRs2, idexMemRead, exBranchTaken;
  logic          exmemMemRead, dmemReady;
  logic          pcWrite, ifidWrite, idexWrite, exmemWrite;
  logic          ifidFlush, idexBubble, memwbBubble, memTimeout;
  logic [CW-1:0] stallCount;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.RF_ADDR_WIDTH(AW), .MAX_WAIT(MW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
    .idexMemRead(idexMemRead), .idexRd(idexRd), .exBranchTaken(exBranchTaken),
    .exmemMemRead(exmemMemRead), .dmemReady(dmemReady),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexWrite(idexWrite),
    .exmemWrite(exmemWrite), .ifidFlush(ifidFlush), .idexBubble(idexBubble),
    .memwbBubble(memwbBubble), .memTimeout(memTimeout),
    .stallCount(stallCount), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    idRs1 = '0; idRs2 = '0; idexRd = '0;
    idUsesRs1 = 1'b0; idUsesRs2 = 1'b0; idexMemRead = 1'b0;
    exBranchTaken = 1'b0; exmemMemRead = 1'b0; dmemReady = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  // reference model: stalled-cycle run length, trap flag, remembered branch,
  // "bubble already given" flag and the saturating stall total
  int m_run = 0;
  bit m_err = 0, m_pend = 0, m_lu_prev = 0;
  int m_scnt = 0;

  always @(negedge clk) begin
    logic       stall, lu, br, issue_lu;
    logic [6:0] exp_o, act_o;
    logic [1:0] exp_st;
    if (rst) begin
      m_run = 0; m_err = 0; m_pend = 0; m_lu_prev = 0; m_scnt = 0;
    end
    stall = !m_err && exmemMemRead && !dmemReady;
    lu    = idexMemRead && (idexRd != 0) &&
            ((idUsesRs1 && idRs1 == idexRd) || (idUsesRs2 && idRs2 == idexRd));
    br    = exBranchTaken || m_pend;
    issue_lu = 1'b0;
    // order: pcWrite ifidWrite idexWrite exmemWrite ifidFlush idexBubble memwbBubble
    if (m_err || stall)          exp_o = 7'b0000_001;
    else if (br)                 exp_o = 7'b1111_110;
    else if (lu && !m_lu_prev) begin
      exp_o = 7'b0011_010;
      issue_lu = 1'b1;
    end else                     exp_o = 7'b1111_000;
    exp_st = m_err ? 2'd2 : (m_run > 0 ? 2'd1 : 2'd0);
    act_o  = {pcWrite, ifidWrite, idexWrite, exmemWrite, ifidFlush, idexBubble, memwbBubble};
    chk("model_outputs", act_o, exp_o);
    chk("model_stall_count", stallCount, m_scnt);
    chk("model_mem_timeout", memTimeout, m_err);
    chk("model_state", dbg_state, exp_st);
    if (!rst) begin
      if (exp_o[6] == 1'b0 && m_scnt < SAT) m_scnt++;
      m_lu_prev = issue_lu;
      if (!m_err) begin
        if (stall) begin
          m_run++;
          m_pend = m_pend | exBranchTaken;
          if (m_run == MW) m_err = 1;
        end else begin
          m_run = 0;
          m_pend = 0;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    step(2);
    chk("reset_pc_write", pcWrite, 1);
    chk("reset_memwb_bubble", memwbBubble, 0);
    chk("reset_stall_count", stallCount, 0);
    rst = 1'b0;
    step(2);

    // load x5 in EX, ID reads rs1=x5
    idexMemRead = 1'b1; idexRd = 5'd5; idRs1 = 5'd5; idUsesRs1 = 1'b1;
    #1;
    chk("lu_pc_write", pcWrite, 0);
    chk("lu_idex_bubble", idexBubble, 1);
    step(1);
    idexMemRead = 1'b0; idexRd = '0;
    #1;
    chk("lu_next_pc_write", pcWrite, 1);
    step(1);
    chk("lu_stall_count", stallCount, 1);

    // held load-use on rs2 gives one bubble only
    idle();
    idexMemRead = 1'b1; idexRd = 5'd9; idRs2 = 5'd9; idUsesRs2 = 1'b1;
    #1;
    chk("lu_rs2_bubble", idexBubble, 1);
    step(1);
    chk("lu_held_second", idexBubble, 0);
    step(1);

    // x0 never interlocks; unused source never interlocks
    idle();
    idexMemRead = 1'b1; idexRd = '0; idRs1 = '0; idUsesRs1 = 1'b1;
    #1;
    chk("lu_x0_pc_write", pcWrite, 1);
    step(1);
    idexRd = 5'd5; idRs1 = 5'd5; idUsesRs1 = 1'b0;
    #1;
    chk("lu_unused_pc_write", pcWrite, 1);
    step(1);

    // taken branch overrides load-use
    idUsesRs1 = 1'b1; exBranchTaken = 1'b1;
    #1;
    chk("br_lu_flush", ifidFlush, 1);
    chk("br_lu_bubble", idexBubble, 1);
    chk("br_lu_pc_write", pcWrite, 1);
    step(1);
    idle();
    step(1);
    chk("stall_count_after_lu", stallCount, 2);

    // three wait cycles then data returns
    pulse_reset();
    exmemMemRead = 1'b1; dmemReady = 1'b0;
    #1;
    chk("mem_memwb_bubble", memwbBubble, 1);
    chk("mem_exmem_write", exmemWrite, 0);
    step(3);
    dmemReady = 1'b1;
    #1;
    chk("mem_release_pc_write", pcWrite, 1);
    chk("mem_release_state", dbg_state, 1);
    step(1);
    idle();
    chk("mem_back_to_run", dbg_state, 0);
    chk("mem_stall_count", stallCount, 3);

    // branch taken while waiting flushes on release
    exmemMemRead = 1'b1; dmemReady = 1'b0; exBranchTaken = 1'b1;
    step(1);
    exBranchTaken = 1'b0;
    step(1);
    dmemReady = 1'b1;
    #1;
    chk("wait_branch_flush", ifidFlush, 1);
    step(1);
    idle();
    #1;
    chk("wait_branch_after", ifidFlush, 0);
    step(1);

    // timeout after MW stalled cycles
    pulse_reset();
    exmemMemRead = 1'b1; dmemReady = 1'b0;
    step(3);
    chk("timeout_not_yet", memTimeout, 0);
    step(1);
    chk("timeout_set", memTimeout, 1);
    chk("timeout_state", dbg_state, 2);
    chk("timeout_pc_write", pcWrite, 0);
    dmemReady = 1'b1;
    #1;
    chk("err_ignores_ready", memwbBubble, 1);
    chk("err_exmem_write", exmemWrite, 0);
    step(2);
    chk("err_stall_count", stallCount, 6);
    rst = 1'b1;
    #1;
    chk("err_reset_timeout", memTimeout, 0);
    chk("err_reset_count", stallCount, 0);
    chk("err_reset_state", dbg_state, 0);
    idle();
    step(1);
    rst = 1'b0;

    // saturation of the stall counter
    exmemMemRead = 1'b1; dmemReady = 1'b0;
    step(20);
    chk("sat_stall_count", stallCount, SAT);
    step(2);
    chk("sat_hold", stallCount, SAT);
    idle();
    pulse_reset();
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
